// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states,
// the STOP word that terminates an image, and the default memory depth.
package riscv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } loader_state_t;

   localparam logic [31:0] STOP_WORD  = 32'h0000_0000;
   localparam int          IMEM_DEPTH = 64;

endpackage

// File: rtl/riscv_byte_packer.sv
// Packs a stream of bytes little-endian into 32-bit words.
// Byte k of a word lands in bits [8k+7:8k]. word_ready pulses for one cycle
// right after the fourth byte, while word_out holds the complete word.
// word_out keeps its value until the next byte of a following word overwrites
// one of its lanes. last_slot tells the owner that the next accepted byte
// completes the word, so its FSM can switch state on that same edge.
module riscv_byte_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic [31:0] word_out,
   output logic        word_ready,
   output logic        last_slot
);

   logic [1:0]  idx_reg;
   logic [31:0] word_reg;
   logic        ready_reg;
   logic [3:0]  lane_we;

   // One write enable per byte lane, selected by the current byte index
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lane_we[gi] = byte_valid && (idx_reg == 2'(gi));
      end
   endgenerate

   // Byte index: restarts on clear, wraps naturally after the fourth byte
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         idx_reg <= 2'd0;
      else if (clear)
         idx_reg <= 2'd0;
      else if (byte_valid)
         idx_reg <= idx_reg + 2'd1;
   end

   // Assembly register: each accepted byte is dropped into its lane
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         word_reg <= 32'h0;
      else
         for (int k = 0; k < 4; k++)
            if (lane_we[k])
               word_reg[8*k +: 8] <= byte_in;
   end

   // Completion pulse, high in the cycle after the fourth byte is taken
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ready_reg <= 1'b0;
      else
         ready_reg <= lane_we[3] && !clear;
   end

   assign word_out   = word_reg;
   assign word_ready = ready_reg;
   assign last_slot  = (idx_reg == 2'd3);

endmodule

// File: rtl/riscv_imem_loader.sv
// Loads a program image into instruction memory from a byte stream.
// Holds the CPU in reset while loading; stops on the STOP word or when the
// last memory slot has been written (flagging overflow in that case).
module riscv_imem_loader
   import riscv_pkg::*;
#(
   parameter int DEPTH  = IMEM_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_wd,
   output logic              cpu_hold,
   output logic              done,
   output logic              overflow,
   output logic [ADDR_W:0]   count
);

   loader_state_t   state_reg, state_next;
   logic [ADDR_W:0] count_reg;
   logic            overflow_reg;
   logic [31:0]     addr_hold_reg;

   logic            accept;
   logic            begin_load;
   logic            last_slot;
   logic            word_ready;
   logic            at_last_slot;
   logic [31:0]     word;
   logic [31:0]     write_addr;

   assign accept       = in_valid && in_ready;
   assign begin_load   = start && ((state_reg == IDLE) || (state_reg == DONE));
   assign write_addr   = 32'({count_reg, 2'b00});
   assign at_last_slot = (count_reg == (ADDR_W+1)'(DEPTH - 1));

   riscv_byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (begin_load),
      .byte_valid (accept),
      .byte_in    (in_data),
      .word_out   (word),
      .word_ready (word_ready),
      .last_slot  (last_slot)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state logic; start is only honoured from IDLE or DONE
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = LOAD;
         LOAD:    if (accept && last_slot) state_next = WRITE;
         WRITE: begin
            if (word == STOP_WORD)
               state_next = DONE;
            else if (at_last_slot)
               state_next = DONE;
            else
               state_next = LOAD;
         end
         DONE:    if (start) state_next = LOAD;
         default: state_next = IDLE;
      endcase
   end

   // Word counter, overflow flag and held address; the packer's completion
   // pulse coincides exactly with the single WRITE cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg     <= '0;
         overflow_reg  <= 1'b0;
         addr_hold_reg <= 32'h0;
      end else if (begin_load) begin
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else if (word_ready) begin
         count_reg     <= count_reg + 1'b1;
         addr_hold_reg <= write_addr;
         if ((word != STOP_WORD) && at_last_slot)
            overflow_reg <= 1'b1;
      end
   end

   // Outputs decoded from state; address is live during WRITE, held otherwise
   always_comb begin
      in_ready = 1'b0;
      mem_we   = 1'b0;
      cpu_hold = 1'b0;
      done     = 1'b0;
      mem_addr = addr_hold_reg;
      case (state_reg)
         LOAD: begin
            in_ready = 1'b1;
            cpu_hold = 1'b1;
         end
         WRITE: begin
            mem_we   = 1'b1;
            cpu_hold = 1'b1;
            mem_addr = write_addr;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   assign mem_wd   = word;
   assign overflow = overflow_reg;
   assign count    = count_reg;

endmodule

// File: tb/tb_riscv_imem_loader.sv
// Directed bench for riscv_imem_loader: byte order, full image, stream gaps,
// ignored start pulses, reload from DONE, overflow on a 4-word memory and
// asynchronous reset in the middle of a load.
module tb_riscv_imem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        start4 = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;

   logic        in_ready, mem_we, cpu_hold, done, overflow;
   logic [31:0] mem_addr, mem_wd;
   logic [6:0]  count;

   logic        in_ready4, mem_we4, cpu_hold4, done4, overflow4;
   logic [31:0] mem_addr4, mem_wd4;
   logic [2:0]  count4;

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;

   logic [31:0] log_addr  [64];
   logic [31:0] log_data  [64];
   int          wr_cnt = 0;
   logic [31:0] log_addr4 [8];
   logic [31:0] log_data4 [8];
   int          wr_cnt4 = 0;

   logic [31:0] image [9] = '{32'h00500093, 32'h00800113, 32'h002081b3,
                              32'h00900213, 32'h003222b3, 32'h00028463,
                              32'h00600313, 32'h006181b3, 32'h00000000};
   logic [31:0] ovf_words [5] = '{32'h11111111, 32'h22222222, 32'h33333333,
                                  32'h44444444, 32'h55555555};

   riscv_imem_loader dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
      .cpu_hold(cpu_hold), .done(done), .overflow(overflow), .count(count)
   );

   riscv_imem_loader #(.DEPTH(4), .ADDR_W(2)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wd(mem_wd4),
      .cpu_hold(cpu_hold4), .done(done4), .overflow(overflow4), .count(count4)
   );

   always #5 clk = ~clk;

   // Write monitors: one line per memory write
   always @(negedge clk) begin
      if (mem_we) begin
         if (wr_cnt < 64) begin
            log_addr[wr_cnt] = mem_addr;
            log_data[wr_cnt] = mem_wd;
         end
         $display("write dut64 #%0d addr=0x%08h data=0x%08h", wr_cnt, mem_addr, mem_wd);
         wr_cnt++;
      end
   end

   always @(negedge clk) begin
      if (mem_we4) begin
         if (wr_cnt4 < 8) begin
            log_addr4[wr_cnt4] = mem_addr4;
            log_data4[wr_cnt4] = mem_wd4;
         end
         $display("write dut4 #%0d addr=0x%08h data=0x%08h", wr_cnt4, mem_addr4, mem_wd4);
         wr_cnt4++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input bit sel4, input logic [7:0] b, input int gap);
      int n;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (!(sel4 ? in_ready4 : in_ready) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         total_cnt++;
         fail_cnt++;
         $error("FAIL handshake_timeout: observed in_ready=0 expected 1 for byte 0x%02h", b);
      end else begin
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic send_word(input bit sel4, input logic [31:0] w, input bit gaps);
      for (int k = 0; k < 4; k++)
         send_byte(sel4, w[8*k +: 8], gaps ? int'($urandom_range(1, 5)) : 0);
   endtask

   task automatic start_pulse(input bit sel4);
      if (sel4) start4 = 1'b1; else start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      start4 = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " in_ready"}, 32'(in_ready), 32'h0);
      check({tag, " mem_we"},   32'(mem_we),   32'h0);
      check({tag, " mem_addr"}, mem_addr,      32'h0);
      check({tag, " mem_wd"},   mem_wd,        32'h0);
      check({tag, " cpu_hold"}, 32'(cpu_hold), 32'h0);
      check({tag, " done"},     32'(done),     32'h0);
      check({tag, " overflow"}, 32'(overflow), 32'h0);
      check({tag, " count"},    32'(count),    32'h0);
   endtask

   task automatic verify_image(input string tag, input int base);
      check({tag, " writes"}, 32'(wr_cnt - base), 32'd9);
      for (int i = 0; i < 9; i++) begin
         check($sformatf("%s addr%0d", tag, i), log_addr[base+i], 32'(4*i));
         check($sformatf("%s data%0d", tag, i), log_data[base+i], image[i]);
      end
   endtask

   initial begin
      int base;

      // Reset state
      repeat (2) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // Byte order and full program
      base = wr_cnt;
      start_pulse(0);
      check("start cpu_hold", 32'(cpu_hold), 32'h1);
      check("start in_ready", 32'(in_ready), 32'h1);
      check("start count",    32'(count),    32'h0);
      send_byte(0, 8'h93, 0);
      send_byte(0, 8'h00, 0);
      send_byte(0, 8'h50, 0);
      send_byte(0, 8'h00, 0);
      check("w0 mem_we",   32'(mem_we),   32'h1);
      check("w0 mem_addr", mem_addr,      32'h0);
      check("w0 mem_wd",   mem_wd,        32'h00500093);
      check("w0 in_ready", 32'(in_ready), 32'h0);
      for (int i = 1; i < 9; i++) send_word(0, image[i], 0);
      @(negedge clk);
      check("full done",     32'(done),     32'h1);
      check("full count",    32'(count),    32'd9);
      check("full overflow", 32'(overflow), 32'h0);
      check("full cpu_hold", 32'(cpu_hold), 32'h0);
      check("full mem_we",   32'(mem_we),   32'h0);
      check("full addr_hold", mem_addr,     32'h20);
      verify_image("full", base);

      // Reload from DONE with random gaps and ignored start pulses
      start_pulse(0);
      check("reload done",     32'(done),     32'h0);
      check("reload overflow", 32'(overflow), 32'h0);
      check("reload count",    32'(count),    32'h0);
      base = wr_cnt;
      for (int i = 0; i < 9; i++) begin
         if (i == 4) begin
            send_byte(0, image[i][7:0], 2);
            send_byte(0, image[i][15:8], 3);
            start_pulse(0);
            check("start_in_load count", 32'(count), 32'(i));
            send_byte(0, image[i][23:16], 1);
            send_byte(0, image[i][31:24], 4);
         end else begin
            send_word(0, image[i], 1);
         end
         if (i == 2) begin
            check("start_in_write mem_we", 32'(mem_we), 32'h1);
            start_pulse(0);
            check("start_in_write count",    32'(count),    32'(i + 1));
            check("start_in_write in_ready", 32'(in_ready), 32'h1);
         end
      end
      @(negedge clk);
      check("gaps done",  32'(done),  32'h1);
      check("gaps count", 32'(count), 32'd9);
      verify_image("gaps", base);

      // Overflow on a 4-word memory
      start_pulse(1);
      for (int i = 0; i < 4; i++) send_word(1, ovf_words[i], 0);
      @(negedge clk);
      check("ovf done",     32'(done4),     32'h1);
      check("ovf overflow", 32'(overflow4), 32'h1);
      check("ovf count",    32'(count4),    32'd4);
      check("ovf cpu_hold", 32'(cpu_hold4), 32'h0);
      check("ovf writes",   32'(wr_cnt4),   32'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ovf addr%0d", i), log_addr4[i], 32'(4*i));
         check($sformatf("ovf data%0d", i), log_data4[i], ovf_words[i]);
      end
      in_valid = 1'b1;
      in_data  = 8'h55;
      repeat (6) @(negedge clk);
      check("ovf in_ready",     32'(in_ready4), 32'h0);
      check("ovf writes_after", 32'(wr_cnt4),   32'd4);
      check("ovf count_after",  32'(count4),    32'd4);
      check("dut64 untouched",  32'(count),     32'd9);
      in_valid = 1'b0;

      // Reset in the middle of word 3
      start_pulse(0);
      for (int i = 0; i < 3; i++) send_word(0, image[i], 0);
      send_byte(0, image[3][7:0], 0);
      send_byte(0, image[3][15:8], 0);
      check("preRst cpu_hold", 32'(cpu_hold), 32'h1);
      check("preRst count",    32'(count),    32'd3);
      rst = 1'b1;
      #1;
      check_idle_outputs("midRst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      base = wr_cnt;
      start_pulse(0);
      check("restart count", 32'(count), 32'h0);
      send_word(0, image[0], 0);
      check("restart mem_addr", mem_addr, 32'h0);
      check("restart mem_wd",   mem_wd,   image[0]);
      for (int i = 1; i < 9; i++) send_word(0, image[i], 0);
      @(negedge clk);
      check("restart done",  32'(done),  32'h1);
      check("restart count_final", 32'(count), 32'd9);
      verify_image("restart", base);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
